dmem_responder: RTL and testbench



---
 rtl/rv32_pkg.sv | 29 ++
 rtl/dmem_lane_align.sv | 48 ++++
 rtl/dmem_responder.sv | 191 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// rv32_pkg : memory-request encodings shared by the memory stage and dmem
// Revision : 1.0
// ============================================================================
package rv32_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_t;

  // Same encoding as the memory stage's exception type
  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_ACCESS   = 2'b10,
    ERR_SIZE     = 2'b11
  } mem_err_t;

  localparam logic [1:0] MEM_ILLEGAL = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == MEM_H) && lo[0]) || ((size == MEM_W) && (lo != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// dmem_lane_align : byte enables, store-data shift and load extract/mask
// Revision        : 1.0
// ============================================================================
module dmem_lane_align
  import rv32_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [4:0]  shamt;
  logic [31:0] rshift;

  always_comb begin
    shamt   = {addr_lo_i, 3'b000};
    wdata_o = wdata_i << shamt;
    rshift  = rword_i >> shamt;
    be_o    = 4'b0000;
    rdata_o = '0;
    case (size_i)
      MEM_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        rdata_o = {24'b0, rshift[7:0]};
      end
      MEM_H: begin
        be_o    = 4'b0011 << addr_lo_i;
        rdata_o = {16'b0, rshift[15:0]};
      end
      MEM_W: begin
        be_o    = 4'b1111;
        rdata_o = rshift;
      end
      default: begin
        be_o    = 4'b0000;
        rdata_o = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder : data-memory target with wait states and fault checking
// Revision       : 1.0
// ============================================================================
module dmem_responder
  import rv32_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           LATENCY    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [1:0]            rsp_err_type_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(LATENCY + 2);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  mem_err_t              rsp_err_type_q, rsp_err_type_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] acc_addr;
  logic                  acc_we;
  logic [1:0]            acc_size;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  out_of_range;
  mem_err_t              acc_err;
  logic                  enter_resp;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] rword;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic [DATA_WIDTH-1:0] load_data;

  // With zero wait states the access coincides with the accept edge, so the
  // live request is used while still in IDLE.
  if (LATENCY == 0) begin : g_lat_zero
    always_comb begin
      acc_addr  = (state_q == IDLE) ? req_addr_i  : addr_q;
      acc_we    = (state_q == IDLE) ? req_we_i    : we_q;
      acc_size  = (state_q == IDLE) ? req_size_i  : size_q;
      acc_wdata = (state_q == IDLE) ? req_wdata_i : wdata_q;
    end
  end else begin : g_lat_wait
    always_comb begin
      acc_addr  = addr_q;
      acc_we    = we_q;
      acc_size  = size_q;
      acc_wdata = wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          we_d    = req_we_i;
          size_d  = req_size_i;
          wdata_d = req_wdata_i;
          cnt_d   = CNT_W'(LATENCY);
          state_d = (LATENCY == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Range check in full address width so high address bits never alias
  always_comb begin
    offset       = acc_addr - BASE_ADDR;
    word_idx     = offset >> 2;
    out_of_range = (acc_addr < BASE_ADDR) || (word_idx >= ADDR_WIDTH'(DEPTH));
    acc_err      = ERR_NONE;
    if (acc_size == MEM_ILLEGAL)                      acc_err = ERR_SIZE;
    else if (is_misaligned(acc_size, acc_addr[1:0]))  acc_err = ERR_MISALIGN;
    else if (out_of_range)                            acc_err = ERR_ACCESS;
  end

  always_comb begin
    rword      = out_of_range ? '0 : mem_q[word_idx[IDX_W-1:0]];
    enter_resp = (state_d == RESP) && (state_q != RESP);
    mem_we     = enter_resp && acc_we && (acc_err == ERR_NONE);
  end

  dmem_lane_align u_lane_align (
    .size_i    (acc_size),
    .addr_lo_i (acc_addr[1:0]),
    .wdata_i   (acc_wdata),
    .rword_i   (rword),
    .be_o      (be),
    .wdata_o   (wdata_sh),
    .rdata_o   (load_data)
  );

  always_comb begin
    rsp_rdata_d    = rsp_rdata_q;
    rsp_err_d      = rsp_err_q;
    rsp_err_type_d = rsp_err_type_q;
    if (enter_resp) begin
      rsp_err_type_d = acc_err;
      rsp_err_d      = (acc_err != ERR_NONE);
      rsp_rdata_d    = (acc_we || (acc_err != ERR_NONE)) ? '0 : load_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      addr_q         <= '0;
      we_q           <= 1'b0;
      size_q         <= 2'b00;
      wdata_q        <= '0;
      rsp_rdata_q    <= '0;
      rsp_err_q      <= 1'b0;
      rsp_err_type_q <= ERR_NONE;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      we_q           <= we_d;
      size_q         <= size_d;
      wdata_q        <= wdata_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_err_q      <= rsp_err_d;
      rsp_err_type_q <= rsp_err_type_d;
    end
  end

  // Array contents survive reset
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[word_idx[IDX_W-1:0]][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  assign req_ready_o    = (state_q == IDLE);
  assign rsp_valid_o    = (state_q == RESP);
  assign rsp_rdata_o    = rsp_rdata_q;
  assign rsp_err_o      = rsp_err_q;
  assign rsp_err_type_o = rsp_err_type_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// tb_dmem_responder : scoreboard bench over LATENCY = 0, 1 and 3 instances
// Revision          : 1.0
// ============================================================================
module tb_dmem_responder;

  localparam int N = 3;
  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11;
  localparam logic [1:0] E_NONE = 2'b00, E_MIS = 2'b01, E_ACC = 2'b10, E_SIZE = 2'b11;
  localparam logic LD = 1'b0, ST = 1'b1;

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n        [N];
  logic        req_valid    [N];
  logic        req_ready    [N];
  logic [31:0] req_addr     [N];
  logic        req_we       [N];
  logic [1:0]  req_size     [N];
  logic [31:0] req_wdata    [N];
  logic        rsp_valid    [N];
  logic        rsp_ready    [N];
  logic [31:0] rsp_rdata    [N];
  logic        rsp_err      [N];
  logic [1:0]  rsp_err_type [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    dmem_responder #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .DEPTH      (1024),
      .BASE_ADDR  (32'h0000_0000),
      .LATENCY    ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .clk_i          (clk),
      .rst_ni         (rst_n[g]),
      .req_valid_i    (req_valid[g]),
      .req_ready_o    (req_ready[g]),
      .req_addr_i     (req_addr[g]),
      .req_we_i       (req_we[g]),
      .req_size_i     (req_size[g]),
      .req_wdata_i    (req_wdata[g]),
      .rsp_valid_o    (rsp_valid[g]),
      .rsp_ready_i    (rsp_ready[g]),
      .rsp_rdata_o    (rsp_rdata[g]),
      .rsp_err_o      (rsp_err[g]),
      .rsp_err_type_o (rsp_err_type[g])
    );
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  etype;
  } exp_t;

  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input int k, input logic we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_size[k]  = size;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
  endtask

  // Present one request at a negedge; it is accepted on the following posedge
  task automatic issue(input int k, input logic we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic [1:0] exp_err);
    exp_t e;
    e.rdata = exp_rdata;
    e.etype = exp_err;
    exp_q.push_back(e);
    @(negedge clk);
    check($sformatf("k%0d_ready_idle", k), 32'(req_ready[k]), 32'd1);
    drive(k, we, size, addr, wdata);
    @(negedge clk);
    req_valid[k] = 1'b0;
  endtask

  task automatic wait_valid(input int k, output int cyc);
    cyc = 1;
    while (!rsp_valid[k] && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("k%0d_rsp_valid", k), 32'(rsp_valid[k]), 32'd1);
    check($sformatf("k%0d_latency", k), 32'(cyc), 32'(lat_of(k) + 1));
  endtask

  task automatic take_rsp(input int k);
    int   cyc;
    exp_t e;
    wait_valid(k, cyc);
    e = exp_q.pop_front();
    check($sformatf("k%0d_rdata", k), rsp_rdata[k], e.rdata);
    check($sformatf("k%0d_err", k), 32'(rsp_err[k]), 32'(e.etype != 2'b00));
    check($sformatf("k%0d_err_type", k), 32'(rsp_err_type[k]), 32'(e.etype));
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    check($sformatf("k%0d_valid_drop", k), 32'(rsp_valid[k]), 32'd0);
    check($sformatf("k%0d_ready_back", k), 32'(req_ready[k]), 32'd1);
    check($sformatf("k%0d_rdata_kept", k), rsp_rdata[k], e.rdata);
  endtask

  task automatic op(input int k, input logic we, input logic [1:0] size,
                    input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [31:0] exp_rdata, input logic [1:0] exp_err);
    issue(k, we, size, addr, wdata, exp_rdata, exp_err);
    take_rsp(k);
  endtask

  task automatic check_reset_outputs(input int k, input string tag);
    check($sformatf("k%0d_%s_req_ready", k, tag), 32'(req_ready[k]), 32'd1);
    check($sformatf("k%0d_%s_rsp_valid", k, tag), 32'(rsp_valid[k]), 32'd0);
    check($sformatf("k%0d_%s_rdata", k, tag), rsp_rdata[k], 32'd0);
    check($sformatf("k%0d_%s_err", k, tag), 32'(rsp_err[k]), 32'd0);
    check($sformatf("k%0d_%s_err_type", k, tag), 32'(rsp_err_type[k]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   cyc;
    for (int i = 0; i < N; i++) begin
      rst_n[i]     = 1'b0;
      req_valid[i] = 1'b0;
      req_addr[i]  = '0;
      req_we[i]    = 1'b0;
      req_size[i]  = 2'b00;
      req_wdata[i] = '0;
      rsp_ready[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) check_reset_outputs(i, "reset");
    for (int i = 0; i < N; i++) rst_n[i] = 1'b1;

    // Basic word access and byte-lane merging
    op(1, ST, SZ_W, 32'h10, 32'hDEADBEEF, 32'h0, E_NONE);
    op(1, LD, SZ_W, 32'h10, 32'h0, 32'hDEADBEEF, E_NONE);
    op(1, ST, SZ_W, 32'h10, 32'h11223344, 32'h0, E_NONE);
    op(1, ST, SZ_B, 32'h13, 32'h000000AA, 32'h0, E_NONE);
    op(1, LD, SZ_W, 32'h10, 32'h0, 32'hAA223344, E_NONE);
    op(1, LD, SZ_H, 32'h12, 32'h0, 32'h0000AA22, E_NONE);
    op(1, LD, SZ_B, 32'h11, 32'h0, 32'h00000033, E_NONE);

    // Misalignment and illegal size, array must stay untouched
    op(1, LD, SZ_W, 32'h0E, 32'h0, 32'h0, E_MIS);
    op(1, ST, SZ_H, 32'h11, 32'h0000FFFF, 32'h0, E_MIS);
    op(1, LD, SZ_X, 32'h11, 32'h0, 32'h0, E_SIZE);
    op(1, ST, SZ_X, 32'h10, 32'h0, 32'h0, E_SIZE);
    op(1, LD, SZ_W, 32'h10, 32'h0, 32'hAA223344, E_NONE);

    // Address range edges
    op(1, LD, SZ_W, 32'h1000, 32'h0, 32'h0, E_ACC);
    op(1, ST, SZ_B, 32'h1003, 32'h55, 32'h0, E_ACC);
    op(1, LD, SZ_W, 32'h1001, 32'h0, 32'h0, E_MIS);
    op(1, LD, SZ_W, 32'h80000010, 32'h0, 32'h0, E_ACC);
    op(1, ST, SZ_W, 32'hFFC, 32'h5A5A5A5A, 32'h0, E_NONE);
    op(1, LD, SZ_W, 32'hFFC, 32'h0, 32'h5A5A5A5A, E_NONE);
    op(1, LD, SZ_H, 32'hFFE, 32'h0, 32'h00005A5A, E_NONE);
    op(1, LD, SZ_W, 32'h10, 32'h0, 32'hAA223344, E_NONE);

    // Upper half-word store
    op(1, ST, SZ_H, 32'h12, 32'h0000BEEF, 32'h0, E_NONE);
    op(1, LD, SZ_W, 32'h10, 32'h0, 32'hBEEF3344, E_NONE);
    op(1, LD, SZ_B, 32'h13, 32'h0, 32'h000000BE, E_NONE);

    // Response backpressure with a competing request held on the bus
    op(1, ST, SZ_W, 32'h40, 32'h0BADF00D, 32'h0, E_NONE);
    issue(1, LD, SZ_W, 32'h40, 32'h0, 32'h0BADF00D, E_NONE);
    wait_valid(1, cyc);
    e = exp_q.pop_front();
    drive(1, LD, SZ_B, 32'h41, 32'h0);
    for (int i = 0; i < 6; i++) begin
      check("bp_valid", 32'(rsp_valid[1]), 32'd1);
      check("bp_rdata", rsp_rdata[1], e.rdata);
      check("bp_err", 32'(rsp_err[1]), 32'd0);
      check("bp_req_ready", 32'(req_ready[1]), 32'd0);
      @(negedge clk);
    end
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    rsp_ready[1] = 1'b0;
    check("bp_valid_drop", 32'(rsp_valid[1]), 32'd0);
    check("bp_not_reaccepted", 32'(req_ready[1]), 32'd1);
    e.rdata = 32'h000000F0;
    e.etype = E_NONE;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid[1] = 1'b0;
    take_rsp(1);

    // Zero wait states
    op(0, ST, SZ_W, 32'h4, 32'h01020304, 32'h0, E_NONE);
    op(0, LD, SZ_H, 32'h6, 32'h0, 32'h00000102, E_NONE);
    op(0, LD, SZ_B, 32'h5, 32'h0, 32'h00000003, E_NONE);
    op(0, LD, SZ_W, 32'h3, 32'h0, 32'h0, E_MIS);

    // Three wait states and reset while waiting
    op(2, ST, SZ_W, 32'h20, 32'hCAFEF00D, 32'h0, E_NONE);
    op(2, LD, SZ_W, 32'h20, 32'h0, 32'hCAFEF00D, E_NONE);
    @(negedge clk);
    drive(2, ST, SZ_W, 32'h20, 32'h12345678);
    @(negedge clk);
    req_valid[2] = 1'b0;
    check("k2_wait_busy", 32'(req_ready[2]), 32'd0);
    @(negedge clk);
    rst_n[2] = 1'b0;
    #1;
    check_reset_outputs(2, "midreset");
    @(negedge clk);
    rst_n[2] = 1'b1;
    op(2, LD, SZ_W, 32'h20, 32'h0, 32'hCAFEF00D, E_NONE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
